serial_word_tx: RTL
===================

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 SHALL have parameter: WIDTH, 4, number of data bits per frame (legal range 1..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: load_valid  input  1  sender offers a word on data_in.
REQ-005 SHALL have port: data_in  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port: load_ready  output  1  block can accept a word; high only in IDLE.
REQ-007 SHALL have port: tx_out  output  1  serial data bit, MSB first.
REQ-008 SHALL have port: tx_valid  output  1  tx_out carries a frame bit this cycle.
REQ-009 SHALL have port: done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-010 SHALL implement states IDLE, SHIFT, DONE (plus PARITY when configured); all outputs registered except load_ready, which is decoded from state.
REQ-011 SHALL accept a word on the rising edge where load_valid=1 and load_ready=1, capturing data_in into an internal shift register.
REQ-012 SHALL enter SHIFT on the accept edge T, presenting data_in[WIDTH-1] on tx_out with tx_valid=1 in cycle T+1.
REQ-013 SHALL present bit WIDTH-1-k in cycle T+1+k for k=0..WIDTH-1, using a bit counter that stops at WIDTH-1 without wrapping.
REQ-014 SHALL enter DONE after the last frame bit, driving done=1, tx_valid=0, tx_out=0 for exactly one cycle, then return to IDLE.
REQ-015 SHALL ignore load_valid and data_in while in SHIFT, PARITY or DONE; no word is queued.
REQ-016 SHALL drive tx_out=0 and tx_valid=0 whenever not in SHIFT or PARITY.
REQ-017 SHALL give a minimum accept-to-accept spacing of WIDTH+2 cycles (WIDTH+3 with parity); back-to-back accepts from IDLE are not possible.
REQ-018 SHALL treat WIDTH=1 as a one-bit frame: SHIFT lasts one cycle.
REQ-019 SHALL keep the captured word stable if data_in changes after acceptance.

Reset
REQ-020 SHALL, on reset=1, immediately and asynchronously enter IDLE and clear shift register, counter, tx_out=0, tx_valid=0, done=0.
REQ-021 SHALL make load_ready=1 while reset is high, and accept no word on any edge while reset is high.
REQ-022 SHALL abort an in-progress frame on reset mid-SHIFT without asserting done; the next accept starts a fresh frame.

Configuration
REQ-023 SHALL, when macro SERIAL_WORD_TX_PARITY_EN is defined, append one PARITY state after the last data bit, driving tx_out = XOR of the captured word (even parity) with tx_valid=1 for one cycle before DONE.
REQ-024 SHALL, when SERIAL_WORD_TX_PARITY_EN is undefined, contain no parity logic and go directly from SHIFT to DONE.

Verification
REQ-025 SHALL cover: reset=1 then released with load_valid=0 -> tx_out=0, tx_valid=0, done=0, load_ready=1 held indefinitely.
REQ-026 SHALL cover: WIDTH=4, accept 4'b1001 at edge T -> tx_out 1,0,0,1 in cycles T+1..T+4 with tx_valid=1; done=1 in T+5; load_ready=1 in T+6.
REQ-027 SHALL cover: accept 4'b1100, then load_valid=1 with data_in=4'b1110 during SHIFT -> tx_out 1,1,0,0 only; 4'b1110 is not transmitted until re-offered in IDLE.
REQ-028 SHALL cover: reset asserted mid-frame after two bits of 4'b1110 -> outputs clear immediately, no done pulse; next accepted 4'b1111 transmits 1,1,1,1.
REQ-029 SHALL cover: with SERIAL_WORD_TX_PARITY_EN, accept 4'b1110 -> bits 1,1,1,0 then parity 1 in cycle T+5; done=1 in T+6.
REQ-030 SHALL cover: load_valid held high continuously with 4'b1001 -> frames repeat with accepts spaced exactly WIDTH+2 cycles (6 for WIDTH=4).

Source files
------------

// File: rtl/serial_word_tx.sv
// serial_word_tx -- parallel-to-serial word transmitter, MSB first.
//
// A word is accepted from data_in on the rising edge where load_valid and
// load_ready are both high. The following WIDTH cycles present one data
// bit per cycle on tx_out with tx_valid high. One cycle with done high
// follows, and the block then returns to IDLE.
//
// Optional feature (macro SERIAL_WORD_TX_PARITY_EN): after the last data
// bit, one extra cycle carries the even parity (XOR) of the captured word
// with tx_valid high, before DONE.
//
// Parameters:
//   WIDTH       data bits per frame (1..32)
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   load_valid  sender offers a word on data_in
//   data_in     parallel word to transmit
//   load_ready  block can accept a word (decoded from state, high in IDLE)
//   tx_out      registered serial data bit
//   tx_valid    registered, tx_out carries a frame bit
//   done        registered one-cycle pulse after the last frame bit
module serial_word_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  output logic             tx_out,
  output logic             tx_valid,
  output logic             done
);

  // Counter is wide enough to index every bit of the word (at least 1 bit).
  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

`ifdef SERIAL_WORD_TX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE   = 2'd2,
    PARITY = 2'd3
  } state_t;

  // Even parity of the captured word.
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [CW-1:0]    bit_idx_s;
  logic             tx_out_r, tx_out_s;
  logic             tx_valid_r, tx_valid_s;
  logic             done_r, done_s;

  // cnt_r is the index k of the bit on tx_out now; the next bit is WIDTH-2-k.
  // Only used when cnt_r < LAST_BIT, so it never underflows.
  assign bit_idx_s = LAST_BIT - cnt_r - CNT_ONE;

  // Ready is decoded straight from state so it is high during reset.
  assign load_ready = (state_r == IDLE);
  assign tx_out     = tx_out_r;
  assign tx_valid   = tx_valid_r;
  assign done       = done_r;

  // Next-state and next-output decode; outputs describe the next cycle.
  always_comb begin
    state_s    = state_r;
    shreg_s    = shreg_r;
    cnt_s      = cnt_r;
    tx_out_s   = 1'b0;
    tx_valid_s = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_valid) begin
          state_s    = SHIFT;
          shreg_s    = data_in;
          cnt_s      = CNT_ZERO;
          tx_out_s   = data_in[WIDTH-1];
          tx_valid_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST_BIT) begin
          // Last data bit is on the line now; the counter holds, no wrap.
`ifdef SERIAL_WORD_TX_PARITY_EN
          state_s    = PARITY;
          tx_out_s   = even_parity(shreg_r);
          tx_valid_s = 1'b1;
`else
          state_s = DONE;
          done_s  = 1'b1;
`endif
        end else begin
          cnt_s      = cnt_r + CNT_ONE;
          tx_out_s   = shreg_r[bit_idx_s];
          tx_valid_s = 1'b1;
        end
      end
`ifdef SERIAL_WORD_TX_PARITY_EN
      PARITY: begin
        state_s = DONE;
        done_s  = 1'b1;
      end
`endif
      DONE: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        shreg_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // State, datapath and registered outputs with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      shreg_r    <= {WIDTH{1'b0}};
      cnt_r      <= CNT_ZERO;
      tx_out_r   <= 1'b0;
      tx_valid_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      shreg_r    <= shreg_s;
      cnt_r      <= cnt_s;
      tx_out_r   <= tx_out_s;
      tx_valid_r <= tx_valid_s;
      done_r     <= done_s;
    end
  end

endmodule
